// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and helpers for the parametrised register file.
//   - REGFILE_DATA_WIDTH / REGFILE_NUM_REGS / REGFILE_ADDR_WIDTH are the
//     default geometry, matching the original fixed 8-bit x 16-entry file.
//   - addr_width_ok() is evaluated at elaboration time to reject address
//     widths too narrow to reach every register.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGFILE_DATA_WIDTH = 8;
  localparam int REGFILE_NUM_REGS   = 16;
  localparam int REGFILE_ADDR_WIDTH = 4;

  // Smallest and largest depth the file is meant to be built with.
  localparam int REGFILE_MIN_REGS = 2;
  localparam int REGFILE_MAX_REGS = 256;

  // True when an address of addr_width bits can reach all num_regs entries.
  function automatic bit addr_width_ok(input int addr_width, input int num_regs);
    return (num_regs <= (1 << addr_width));
  endfunction

  // True when the depth lies within the supported range.
  function automatic bit num_regs_ok(input int num_regs);
    return (num_regs >= REGFILE_MIN_REGS) && (num_regs <= REGFILE_MAX_REGS);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
//   One registered read port of param_regfile.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     raddr        read address presented this cycle
//     regs         register contents as they will stand after this edge
//                  (already reflects a same-cycle restore)
//     wr_accept    a write to an in-range address is being accepted now
//     waddr/wdata  address and data of that write, used for the bypass
//     rdata        registered read data (1-cycle latency)
//     err          combinational flag: raddr is out of range this cycle
//   Priority of the read mux, lowest to highest: array, bypass, out-of-range
//   zero, hardwired-zero register 0.
// -----------------------------------------------------------------------------
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int NUM_REGS   = REGFILE_NUM_REGS,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic                  wr_accept,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  // Depth expressed one bit wider than the address, so the range compare is
  // meaningful even when NUM_REGS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  logic                  in_range;
  logic [DATA_WIDTH-1:0] sel_data;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it holding an old value (no latch).
  always_comb begin
    in_range = ({1'b0, raddr} < NUM_REGS_W);
    sel_data = '0;

    // Decoded mux rather than a direct index: never reads past the array for
    // depths that are not a power of two.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_WIDTH'(i)) begin
        sel_data = regs[i];
      end
    end

    // Same-cycle write to the address being read wins over the array, which
    // also covers the restore-plus-write case: the written address returns
    // wdata, every other address returns the restored value via regs.
    if (wr_accept && (waddr == raddr)) begin
      sel_data = wdata;
    end

    if (!in_range) begin
      sel_data = '0;
    end

    if ((ZERO_REG != 0) && (raddr == '0)) begin
      sel_data = '0;
    end
  end

  assign err = !in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= sel_data;
    end
  end

endmodule : regfile_rd_port

// File: rtl/param_regfile.sv
// -----------------------------------------------------------------------------
// param_regfile
//   Parametrised register file: one write port, two registered read ports
//   with write-to-read bypass, optional hardwired-zero r0, overflow flag and
//   a single-level shadow bank for one-cycle context save/restore.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     we_i, waddr_i, wdata_i write port
//     ovf_i                  overflow condition, captured on accepted writes
//     raddr_a_i, raddr_b_i   read addresses
//     rdata_a_o, rdata_b_o   registered read data
//     ovf_o                  overflow flag
//     save_i, restore_i      shadow bank save / restore requests
//     shadow_valid_o         shadow bank holds a saved context
//     err_o                  one-cycle pulse after any illegal access
// -----------------------------------------------------------------------------
module param_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int NUM_REGS   = REGFILE_NUM_REGS,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  ovf_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic                  ovf_o,
  input  logic                  save_i,
  input  logic                  restore_i,
  output logic                  shadow_valid_o,
  output logic                  err_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // ---------------------------------------------------------------------------
  if (!addr_width_ok(ADDR_WIDTH, NUM_REGS)) begin : g_bad_addr_width
    $error("param_regfile: 2**ADDR_WIDTH (%0d) is less than NUM_REGS (%0d)",
           1 << ADDR_WIDTH, NUM_REGS);
  end

  if (!num_regs_ok(NUM_REGS)) begin : g_bad_num_regs
    $error("param_regfile: NUM_REGS (%0d) outside %0d..%0d",
           NUM_REGS, REGFILE_MIN_REGS, REGFILE_MAX_REGS);
  end

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] live_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic                  shadow_valid_q;
  logic                  ovf_q;
  logic                  err_q;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic wr_in_range;
  logic wr_accept;    // write is legal: updates ovf and feeds the bypass
  logic wr_store;     // write actually lands in the live array
  logic wr_err;
  logic restore_ok;
  logic restore_err;
  logic rd_err_a;
  logic rd_err_b;

  assign wr_in_range = ({1'b0, waddr_i} < NUM_REGS_W);
  assign wr_accept   = we_i && wr_in_range;
  assign wr_err      = we_i && !wr_in_range;

  // With a hardwired-zero r0 the write is still accepted (ovf_o follows it)
  // but the data is discarded.
  assign wr_store    = wr_accept && !((ZERO_REG != 0) && (waddr_i == '0));

  // Restore only acts on a valid shadow. A restore with an empty shadow that
  // coincides with a save is treated as a plain save and raises no error.
  assign restore_ok  = restore_i && shadow_valid_q;
  assign restore_err = restore_i && !shadow_valid_q && !save_i;

  // ---------------------------------------------------------------------------
  // Read source: the contents the live bank will hold after this edge,
  // ignoring the write (the read ports apply the write via their bypass).
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_src[i] = restore_ok ? shadow_q[i] : live_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Live and shadow banks
  // ---------------------------------------------------------------------------
  // NOTE: both arrays are built from flops rather than a RAM macro, so they
  // can and do take the reset, which lets the whole file clear in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // Save and restore both read the pre-edge values, so asserting both
        // swaps the banks.
        if (restore_ok) begin
          live_q[i] <= shadow_q[i];
        end
        if (save_i) begin
          shadow_q[i] <= live_q[i];
        end
        // Later assignment wins: a same-cycle write overrides the restore.
        if (wr_store && (waddr_i == ADDR_WIDTH'(i))) begin
          live_q[i] <= wdata_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow-valid, overflow flag and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // Save has priority, which keeps the flag set across a swap.
      if (save_i) begin
        shadow_valid_q <= 1'b1;
      end else if (restore_ok) begin
        shadow_valid_q <= 1'b0;
      end

      if (wr_accept) begin
        ovf_q <= ovf_i;
      end

      // Recomputed every cycle, so the flag is a single-cycle pulse.
      err_q <= wr_err || rd_err_a || rd_err_b || restore_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  regfile_rd_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rd_port_a (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr_a_i),
    .regs      (rd_src),
    .wr_accept (wr_accept),
    .waddr     (waddr_i),
    .wdata     (wdata_i),
    .rdata     (rdata_a_o),
    .err       (rd_err_a)
  );

  regfile_rd_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rd_port_b (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr_b_i),
    .regs      (rd_src),
    .wr_accept (wr_accept),
    .waddr     (waddr_i),
    .wdata     (wdata_i),
    .rdata     (rdata_b_o),
    .err       (rd_err_b)
  );

  assign ovf_o          = ovf_q;
  assign shadow_valid_o = shadow_valid_q;
  assign err_o          = err_q;

endmodule : param_regfile

// File: tb/tb_param_regfile.sv
// -----------------------------------------------------------------------------
// tb_param_regfile
//   Two instances share one stimulus stream:
//     dut_a : NUM_REGS=12, ADDR_WIDTH=4, ZERO_REG=0 (out-of-range addresses)
//     dut_z : NUM_REGS=16, ADDR_WIDTH=4, ZERO_REG=1 (hardwired-zero r0)
//   Each driven cycle runs a behavioural model of both configurations and
//   queues the expected outputs; after the edge the queue is drained and
//   compared against the instances.
// -----------------------------------------------------------------------------
module tb_param_regfile;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int NR_A = 12;
  localparam int NR_Z = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          ovf_in;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic          save;
  logic          restore;

  logic [DW-1:0] rda_a, rdb_a, rda_z, rdb_z;
  logic          ovf_a, ovf_z, sv_a, sv_z, err_a, err_z;

  always #5 clk = ~clk;

  param_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR_A), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .ovf_i(ovf_in),
    .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rda_a), .rdata_b_o(rdb_a), .ovf_o(ovf_a),
    .save_i(save), .restore_i(restore), .shadow_valid_o(sv_a), .err_o(err_a)
  );

  param_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR_Z), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .ovf_i(ovf_in),
    .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rda_z), .rdata_b_o(rdb_z), .ovf_o(ovf_z),
    .save_i(save), .restore_i(restore), .shadow_valid_o(sv_z), .err_o(err_z)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int            inst;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          ovf;
    logic          sv;
    logic          err;
  } exp_t;

  exp_t sb_q[$];

  logic [DW-1:0] m_live   [2][16];
  logic [DW-1:0] m_shadow [2][16];
  logic          m_valid  [2];
  logic          m_ovf    [2];
  int            m_nregs  [2] = '{NR_A, NR_Z};
  bit            m_zero   [2] = '{1'b0, 1'b1};

  function automatic logic [DW-1:0] m_read(input int k, input int a, input bit rok,
                                           input bit wacc, input int wa, input logic [DW-1:0] wd);
    if (a >= m_nregs[k]) return '0;
    if (m_zero[k] && a == 0) return '0;
    if (wacc && wa == a) return wd;
    return rok ? m_shadow[k][a] : m_live[k][a];
  endfunction

  task automatic model_step(input int k);
    exp_t          e;
    bit            rok;
    bit            wacc;
    logic [DW-1:0] old_live [16];
    e.inst = k;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_live[k][i]   = '0;
        m_shadow[k][i] = '0;
      end
      m_valid[k] = 1'b0;
      m_ovf[k]   = 1'b0;
      e.rd_a = '0; e.rd_b = '0; e.ovf = 1'b0; e.sv = 1'b0; e.err = 1'b0;
    end else begin
      rok  = restore && m_valid[k];
      wacc = we && (int'(waddr) < m_nregs[k]);
      e.rd_a = m_read(k, int'(ra), rok, wacc, int'(waddr), wdata);
      e.rd_b = m_read(k, int'(rb), rok, wacc, int'(waddr), wdata);
      e.err  = (we && !wacc) || (int'(ra) >= m_nregs[k]) || (int'(rb) >= m_nregs[k]) ||
               (restore && !save && !m_valid[k]);
      old_live = m_live[k];
      for (int i = 0; i < 16; i++) begin
        if (rok)  m_live[k][i]   = m_shadow[k][i];
        if (save) m_shadow[k][i] = old_live[i];
      end
      if (wacc && !(m_zero[k] && waddr == '0)) m_live[k][waddr] = wdata;
      if (wacc) m_ovf[k] = ovf_in;
      if (save) m_valid[k] = 1'b1;
      else if (rok) m_valid[k] = 1'b0;
      e.ovf = m_ovf[k];
      e.sv  = m_valid[k];
    end
    sb_q.push_back(e);
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic cyc(input bit r, input bit w, input int wa, input int wd, input bit o,
                     input int a, input int b, input bit s, input bit rs);
    exp_t  e;
    string t;
    rst = r; we = w; waddr = AW'(wa); wdata = DW'(wd); ovf_in = o;
    ra = AW'(a); rb = AW'(b); save = s; restore = rs;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cycle_no++;
    repeat (2) begin
      if (sb_q.size() == 0) begin
        check($sformatf("c%0d scoreboard_empty", cycle_no), 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        t = $sformatf("c%0d %s", cycle_no, (e.inst == 0) ? "dut_a" : "dut_z");
        if (e.inst == 0) begin
          check({t, " rdata_a"}, 32'(rda_a), 32'(e.rd_a));
          check({t, " rdata_b"}, 32'(rdb_a), 32'(e.rd_b));
          check({t, " ovf"},     32'(ovf_a), 32'(e.ovf));
          check({t, " shadow_valid"}, 32'(sv_a), 32'(e.sv));
          check({t, " err"},     32'(err_a), 32'(e.err));
        end else begin
          check({t, " rdata_a"}, 32'(rda_z), 32'(e.rd_a));
          check({t, " rdata_b"}, 32'(rdb_z), 32'(e.rd_b));
          check({t, " ovf"},     32'(ovf_z), 32'(e.ovf));
          check({t, " shadow_valid"}, 32'(sv_z), 32'(e.sv));
          check({t, " err"},     32'(err_z), 32'(e.err));
        end
      end
    end
  endtask

  // Idle cycle reading two addresses.
  task automatic rd(input int a, input int b);
    cyc(0, 0, 0, 0, 0, a, b, 0, 0);
  endtask

  // Plain write cycle with reads parked on r1/r2.
  task automatic wr(input int wa, input int wd, input bit o);
    cyc(0, 1, wa, wd, o, 1, 2, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ovf_in = 1'b0;
    ra = '0; rb = '0; save = 1'b0; restore = 1'b0;

    // Reset.
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0);

    // Fill every address (12..15 are out of range on dut_a), save, set ovf.
    for (int i = 0; i < 16; i++) wr(i, 8'h80 + i, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 2, 1, 0);

    // Reset with loaded state, then read every address back.
    cyc(1, 1, 5, 8'h5A, 1, 1, 2, 1, 1);
    for (int i = 0; i < 16; i++) rd(i, 15 - i);

    // Bypass: r4=0x11 first, then write r3 while port A reads r3, B reads r4.
    wr(4, 8'h11, 1'b0);
    cyc(0, 1, 3, 8'hA5, 0, 3, 4, 0, 0);
    rd(3, 4);

    // Zero register: write 0xFF to r0 with ovf=1, read r0 on both ports.
    cyc(0, 1, 0, 8'hFF, 1, 0, 0, 0, 0);
    rd(0, 0);

    // Out of range write to 13, then read 13 and neighbours.
    cyc(0, 1, 13, 8'h77, 0, 3, 4, 0, 0);
    rd(13, 11);
    rd(11, 3);

    // Save / restore with a same-cycle write.
    wr(1, 8'h10, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 2, 1, 0);
    wr(1, 8'h20, 1'b0);
    cyc(0, 1, 2, 8'h33, 0, 1, 2, 0, 1);
    rd(1, 2);
    cyc(0, 0, 0, 0, 0, 1, 2, 0, 1);
    rd(1, 2);

    // Restore legal one edge after a save.
    cyc(0, 0, 0, 0, 0, 1, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 0, 1);

    // Swap: live r5=0x55, shadow r5=0xAA, then save+restore together.
    wr(5, 8'hAA, 1'b0);
    cyc(0, 0, 0, 0, 0, 5, 1, 1, 0);
    wr(5, 8'h55, 1'b0);
    cyc(0, 0, 0, 0, 0, 5, 1, 1, 1);
    rd(5, 1);
    cyc(0, 0, 0, 0, 0, 5, 1, 0, 1);
    rd(5, 1);

    // Save+restore with an empty shadow behaves as a plain save.
    cyc(0, 0, 0, 0, 0, 5, 1, 1, 1);
    rd(5, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 1),
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 11),
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 11),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_param_regfile
